// File: rtl/replay_tx.sv
// Go-back-N replay transmitter: buffers input words by sequence number, presents
// them on a registered output, retires on cumulative acks and rewinds on replay.
module replay_tx #(
  parameter int W  = 32,
  parameter int D  = 8,
  parameter int SW = $clog2(D) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in,
  input  logic          in_vld,
  output logic          in_accept,
  output logic [W-1:0]  out_r,
  output logic [SW-1:0] out_seq_r,
  output logic          out_vld_r,
  input  logic          out_accept,
  input  logic          ack_vld,
  input  logic [SW-1:0] ack_seq,
  input  logic          replay_req,
  output logic [SW-1:0] outstanding_r,
  output logic          ack_err_r
);

  localparam int IW = $clog2(D);
  localparam logic [SW-1:0] DEPTH = SW'(D);
  localparam logic [SW-1:0] ONE   = SW'(1);

  logic [W-1:0]  mem_q [D];
  logic [SW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0] spec_ptr_q, spec_ptr_d;
  logic [SW-1:0] arch_ptr_q, arch_ptr_d;
  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] out_seq_q, out_seq_d;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] outstanding_q, outstanding_d;
  logic          ack_err_q, ack_err_d;

  logic          wr_en;
  logic          load;
  logic          ack_ok;
  logic [SW-1:0] sent;
  logic [SW-1:0] ack_dist;

  always_comb begin
    in_accept     = ((wr_ptr_q - arch_ptr_q) != DEPTH);
    wr_en         = in_vld & in_accept;
    wr_ptr_d      = wr_en ? wr_ptr_q + ONE : wr_ptr_q;

    // Words already taken downstream; the one sitting in the output reg is not yet sent.
    sent          = (spec_ptr_q - arch_ptr_q) - {{(SW-1){1'b0}}, out_vld_q};
    ack_dist      = ack_seq - arch_ptr_q;
    ack_ok        = ack_vld & (ack_dist < sent);
    arch_ptr_d    = ack_ok ? ack_seq + ONE : arch_ptr_q;
    ack_err_d     = ack_err_q | (ack_vld & ~ack_ok);

    spec_ptr_d    = spec_ptr_q;
    out_d         = out_q;
    out_seq_d     = out_seq_q;
    out_vld_d     = out_vld_q;
    load          = 1'b0;

    if (replay_req) begin
      // Rewind to the oldest word still unacked after this cycle's ack.
      spec_ptr_d  = arch_ptr_d;
      out_vld_d   = 1'b0;
    end else begin
      load        = (~out_vld_q | out_accept) & (spec_ptr_q != wr_ptr_q);
      if (load) begin
        out_d      = mem_q[spec_ptr_q[IW-1:0]];
        out_seq_d  = spec_ptr_q;
        spec_ptr_d = spec_ptr_q + ONE;
        out_vld_d  = 1'b1;
      end else if (out_accept) begin
        out_vld_d  = 1'b0;
      end
    end

    outstanding_d = wr_ptr_d - arch_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[IW-1:0]] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      spec_ptr_q    <= '0;
      arch_ptr_q    <= '0;
      out_q         <= '0;
      out_seq_q     <= '0;
      out_vld_q     <= 1'b0;
      outstanding_q <= '0;
      ack_err_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      spec_ptr_q    <= spec_ptr_d;
      arch_ptr_q    <= arch_ptr_d;
      out_q         <= out_d;
      out_seq_q     <= out_seq_d;
      out_vld_q     <= out_vld_d;
      outstanding_q <= outstanding_d;
      ack_err_q     <= ack_err_d;
    end
  end

  assign out_r         = out_q;
  assign out_seq_r     = out_seq_q;
  assign out_vld_r     = out_vld_q;
  assign outstanding_r = outstanding_q;
  assign ack_err_r     = ack_err_q;

endmodule

// File: tb/tb_replay_tx.sv
// Directed bench for replay_tx (W=32, D=8, SW=4): hand-computed expectations
// covering streaming, full stall, acks, replay, bad acks, wrap and reset.
module tb_replay_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic        in_vld;
  logic        in_accept;
  logic [31:0] out_r;
  logic [3:0]  out_seq_r;
  logic        out_vld_r;
  logic        out_accept;
  logic        ack_vld;
  logic [3:0]  ack_seq;
  logic        replay_req;
  logic [3:0]  outstanding_r;
  logic        ack_err_r;

  int n_cmp = 0;
  int n_err = 0;

  replay_tx #(.W(32), .D(8)) dut (
    .clk(clk), .rst(rst),
    .in(in), .in_vld(in_vld), .in_accept(in_accept),
    .out_r(out_r), .out_seq_r(out_seq_r), .out_vld_r(out_vld_r),
    .out_accept(out_accept),
    .ack_vld(ack_vld), .ack_seq(ack_seq), .replay_req(replay_req),
    .outstanding_r(outstanding_r), .ack_err_r(ack_err_r)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic [3:0] s);
    chk({tag, "_vld"}, {31'd0, out_vld_r}, 32'd1);
    chk({tag, "_data"}, out_r, d);
    chk({tag, "_seq"}, {28'd0, out_seq_r}, {28'd0, s});
  endtask

  initial begin
    rst = 1'b1; in = '0; in_vld = 1'b0; out_accept = 1'b0;
    ack_vld = 1'b0; ack_seq = '0; replay_req = 1'b0;
    tick; tick;
    chk("rst_vld", {31'd0, out_vld_r}, 32'd0);
    chk("rst_data", out_r, 32'd0);
    chk("rst_seq", {28'd0, out_seq_r}, 32'd0);
    chk("rst_outst", {28'd0, outstanding_r}, 32'd0);
    chk("rst_err", {31'd0, ack_err_r}, 32'd0);
    chk("rst_inacc", {31'd0, in_accept}, 32'd1);

    // Stream A0..A3, downstream always accepting.
    rst = 1'b0; out_accept = 1'b1; in_vld = 1'b1; in = 32'hA0;
    tick;
    chk("s1_lat_vld", {31'd0, out_vld_r}, 32'd0);
    in = 32'hA1; tick; chk_out("s1_w0", 32'hA0, 4'd0);
    in = 32'hA2; tick; chk_out("s1_w1", 32'hA1, 4'd1);
    in = 32'hA3; tick; chk_out("s1_w2", 32'hA2, 4'd2);
    in_vld = 1'b0; tick; chk_out("s1_w3", 32'hA3, 4'd3);
    chk("s1_outst", {28'd0, outstanding_r}, 32'd4);
    tick;
    chk("s1_idle", {31'd0, out_vld_r}, 32'd0);
    ack_vld = 1'b1; ack_seq = 4'd3; tick;
    ack_vld = 1'b0;
    chk("s1_ackall", {28'd0, outstanding_r}, 32'd0);

    // Fill the buffer with B0..B7 while downstream stalls (pointers now at 4).
    out_accept = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 32'hB0 + i;
      tick;
    end
    chk("s2_full_outst", {28'd0, outstanding_r}, 32'd8);
    chk("s2_full_inacc", {31'd0, in_accept}, 32'd0);
    in = 32'hC9; tick;
    chk("s2_blocked_outst", {28'd0, outstanding_r}, 32'd8);
    chk_out("s2_hold", 32'hB0, 4'd4);
    in_vld = 1'b0; out_accept = 1'b1;
    tick; tick; tick;
    chk_out("s2_after3", 32'hB3, 4'd7);
    out_accept = 1'b0; ack_vld = 1'b1; ack_seq = 4'd6; tick;
    ack_vld = 1'b0;
    chk("s2_ack_outst", {28'd0, outstanding_r}, 32'd5);
    chk("s2_ack_inacc", {31'd0, in_accept}, 32'd1);
    chk_out("s2_stall_hold", 32'hB3, 4'd7);

    // Send seq 7..9, ack 7, replay while seq 10 is being sent.
    out_accept = 1'b1; tick; tick; tick;
    chk_out("s3_pre", 32'hB6, 4'd10);
    out_accept = 1'b0; ack_vld = 1'b1; ack_seq = 4'd7; tick;
    ack_vld = 1'b0;
    chk("s3_ack_outst", {28'd0, outstanding_r}, 32'd4);
    out_accept = 1'b1; replay_req = 1'b1; tick;
    replay_req = 1'b0;
    chk("s3_rewind_vld", {31'd0, out_vld_r}, 32'd0);
    tick; chk_out("s3_r8", 32'hB4, 4'd8);
    tick; chk_out("s3_r9", 32'hB5, 4'd9);
    in_vld = 1'b1; in = 32'hD0;
    tick; chk_out("s3_r10", 32'hB6, 4'd10);
    in_vld = 1'b0;
    tick; chk_out("s3_r11", 32'hB7, 4'd11);
    tick; chk_out("s3_new12", 32'hD0, 4'd12);
    chk("s3_outst", {28'd0, outstanding_r}, 32'd5);

    // Replay with a same-cycle ack of seq 10 (seq 8..11 sent).
    out_accept = 1'b0; ack_vld = 1'b1; ack_seq = 4'd10; replay_req = 1'b1; tick;
    ack_vld = 1'b0; replay_req = 1'b0;
    chk("s4_vld", {31'd0, out_vld_r}, 32'd0);
    chk("s4_outst", {28'd0, outstanding_r}, 32'd2);
    tick; chk_out("s4_r11", 32'hB7, 4'd11);
    out_accept = 1'b1;
    tick; chk_out("s4_r12", 32'hD0, 4'd12);
    tick;
    chk("s4_idle", {31'd0, out_vld_r}, 32'd0);
    chk("s4_err_clear", {31'd0, ack_err_r}, 32'd0);

    // Out-of-window ack (only 11,12 sent), then a good ack; error stays sticky.
    ack_vld = 1'b1; ack_seq = 4'd13; tick;
    chk("s5_err", {31'd0, ack_err_r}, 32'd1);
    chk("s5_outst_kept", {28'd0, outstanding_r}, 32'd2);
    ack_seq = 4'd12; tick;
    ack_vld = 1'b0;
    chk("s5_good_outst", {28'd0, outstanding_r}, 32'd0);
    chk("s5_err_sticky", {31'd0, ack_err_r}, 32'd1);

    // 20 words streamed across the 15->0 wrap with acks on odd cycles.
    for (int j = 0; j <= 21; j++) begin
      in_vld  = (j < 20);
      in      = 32'hE00 + j;
      ack_vld = (j >= 3) && (j % 2 == 1);
      ack_seq = 4'(13 + j - 3);
      tick;
      if (j >= 1 && j <= 20) begin
        chk_out("s6_wrap", 32'hE00 + j - 1, 4'(13 + j - 1));
      end else begin
        chk("s6_edge_vld", {31'd0, out_vld_r}, 32'd0);
      end
    end
    in_vld = 1'b0; ack_vld = 1'b1; ack_seq = 4'd0; tick;
    ack_vld = 1'b0;
    chk("s6_final_outst", {28'd0, outstanding_r}, 32'd0);

    // Reset mid-stream discards everything; first new word gets seq 0.
    out_accept = 1'b0; in_vld = 1'b1;
    in = 32'hF0; tick; in = 32'hF1; tick; in = 32'hF2; tick;
    chk_out("s7_pre", 32'hF0, 4'd1);
    chk("s7_pre_outst", {28'd0, outstanding_r}, 32'd3);
    in_vld = 1'b0; rst = 1'b1; tick;
    rst = 1'b0;
    chk("s7_rst_vld", {31'd0, out_vld_r}, 32'd0);
    chk("s7_rst_outst", {28'd0, outstanding_r}, 32'd0);
    chk("s7_rst_err", {31'd0, ack_err_r}, 32'd0);
    in_vld = 1'b1; in = 32'h77; tick;
    in_vld = 1'b0; tick;
    chk_out("s7_first", 32'h77, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
